ring_ctrl: RTL and testbench
============================

Name: ring_ctrl

Overview:
- Control stage directly upstream of the ring/border pixel renderer, in the 6.25 MHz OLED clock domain.
- Turns raw btnC/btnU/btnD levels into a ring-enable flag and a bounded outer diameter for the renderer.
- Debounces all three buttons; btnU/btnD auto-repeat while held.
- Outputs change only on the OLED driver's frame_begin pulse, so a frame never tears mid-scan.

Parameters:
- DB_CYCLES, 12500: stable-high cycles needed before a press is accepted (2 ms at 6.25 MHz).
- HOLD_CYCLES, 3125000: cycles held after acceptance before auto-repeat starts (0.5 s).
- REPEAT_CYCLES, 625000: cycles between auto-repeat pulses (0.1 s).
- DIA_W, 8: width of diameter outputs.
- DIA_INIT, 30: reset outer diameter.
- DIA_MIN, 10: lower bound of outer diameter.
- DIA_MAX, 50: upper bound of outer diameter.
- DIA_STEP, 5: change per up/down event.
- RING_WIDTH, 5: outer minus inner diameter. Requires DIA_MIN >= RING_WIDTH.

Ports:
- clk  in  1  6.25 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- btnC  in  1  raw centre button.
- btnU  in  1  raw up button.
- btnD  in  1  raw down button.
- frame_begin  in  1  one-cycle pulse from the OLED driver at frame start.
- ring_active  out  1  committed ring-enable flag.
- outer_dia  out  DIA_W  committed outer diameter.
- inner_dia  out  DIA_W  outer_dia - RING_WIDTH (combinational from the committed register).
- update_pending  out  1  target state differs from committed state.

Behaviour:
- Reset (reset=0, asynchronous):
  - ring_active=0, outer_dia=DIA_INIT, inner_dia=DIA_INIT-RING_WIDTH, update_pending=0.
  - All synchronisers, counters and FSMs return to IDLE.
  - Applies mid-press or mid-repeat: no pulse is emitted after reset deasserts until a fresh DB_CYCLES qualification completes.
- Input sync: each button passes a 2-flop synchroniser.
- Per-button event FSM (states IDLE, WAIT, HELD, REPEAT):
  - IDLE: synced=1 -> WAIT, counter cleared.
  - WAIT: counter increments each cycle while synced=1. synced=0 -> IDLE with no pulse. When counter reaches DB_CYCLES-1 with synced=1, emit a one-cycle press pulse on the next cycle and go to HELD.
  - HELD: count to HOLD_CYCLES-1, then pulse and go to REPEAT. With repeat disabled, stay in HELD until release.
  - REPEAT: pulse every REPEAT_CYCLES while held.
  - Release (synced=0) in HELD or REPEAT -> IDLE, no pulse.
  - Counters saturate and never wrap.
- Target registers (tgt_active, tgt_dia):
  - C pulse toggles tgt_active. tgt_dia is kept across toggles.
  - U pulse with tgt_active=1: if tgt_dia+DIA_STEP <= DIA_MAX, tgt_dia += DIA_STEP; otherwise unchanged (saturate, no wrap).
  - D pulse with tgt_active=1: if tgt_dia >= DIA_MIN+DIA_STEP, tgt_dia -= DIA_STEP; otherwise unchanged.
  - U and D pulses while tgt_active=0 are discarded.
  - U and D pulses in the same cycle: both discarded.
  - C in the same cycle as U or D: C toggles. The U/D pulse is judged against tgt_active before the toggle.
- Commit:
  - On frame_begin=1: ring_active<=tgt_active, outer_dia<=tgt_dia.
  - Commit samples the target registers' pre-update values. An event in the same cycle as frame_begin takes effect at the next frame_begin.
- update_pending = (tgt_active!=ring_active) || (tgt_dia!=outer_dia), registered.
- Arithmetic: compare in DIA_W+1 bits so that DIA_MAX near 2^DIA_W cannot overflow.

Decomposition:
- Shared package: button-event FSM state encoding (IDLE/WAIT/HELD/REPEAT) and the default timing constants (6.25 MHz CLK_FREQ, DB/HOLD/REPEAT cycles). The renderer and any other button consumers reuse these.
- One sub-module, btn_event:
  - Contents: synchroniser, FSM, counter.
  - Parameters: DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, REPEAT_EN.
  - Output: one-cycle pulse.
  - Instantiated three times: btnC with REPEAT_EN=0, btnU and btnD with REPEAT_EN=1.

Test Plan:
All scenarios use DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, with frame_begin pulsed every 50 cycles unless stated otherwise.
- Reset release -> ring_active=0, outer_dia=30, inner_dia=25, update_pending=0. No pulses during 100 idle cycles.
- btnC high for 3 cycles then low -> no toggle. btnC held 10 cycles -> tgt_active=1, update_pending=1 until the next frame_begin, then ring_active=1 and update_pending=0.
- Active; btnU pulsed (held 6 cycles) 5 times, each press spaced >=50 cycles apart so a frame_begin falls between presses -> outer_dia 35, 40, 45, 50, 50 (saturated). Then 9 btnD presses -> outer_dia settles at 10, never below.
- Active, outer_dia=30; btnU held 40 cycles -> one press pulse, repeat pulses at +20 and +28 cycles after acceptance -> tgt_dia=45. Committed on the next frame_begin only.
- btnU and btnD pulses aligned to the same cycle -> tgt_dia unchanged. Inactive state plus btnU press -> tgt_dia unchanged, ring_active stays 0.
- reset asserted during REPEAT with btnU still held, then released -> tgt_dia and outer_dia=30 at release. First new pulse comes no earlier than 2+DB_CYCLES cycles after release.

Source files
------------

// File: rtl/ring_ctrl_pkg.sv
// Shared definitions for button-event consumers in the OLED clock domain.
package ring_ctrl_pkg;

    localparam int unsigned CLK_FREQ          = 6_250_000;
    localparam int unsigned BTN_DB_CYCLES     = 12_500;     // 2 ms
    localparam int unsigned BTN_HOLD_CYCLES   = 3_125_000;  // 0.5 s
    localparam int unsigned BTN_REPEAT_CYCLES = 625_000;    // 0.1 s

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_WAIT,
        BTN_HELD,
        BTN_REPEAT
    } btn_state_e;

endpackage

// File: rtl/ring_ctrl_btn_event.sv
// Button event generator: 2-flop synchroniser, debounce, hold delay and
// optional auto-repeat. Emits one-cycle pulses on pulse_o.
module btn_event
    import ring_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = BTN_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = BTN_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CNT_MAX_A = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > REPEAT_CYCLES) ? CNT_MAX_A : REPEAT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic [1:0]       sync_q;
    logic             synced;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pulse_q, pulse_d;

    assign synced  = sync_q[1];
    assign pulse_o = pulse_q;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // Synchroniser, state, counter and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: debounce, hold delay, repeat cadence; release aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            BTN_IDLE: begin
                cnt_d = '0;
                if (synced) state_d = BTN_WAIT;
            end
            BTN_WAIT: begin
                if (!synced) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = BTN_HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            BTN_HELD: begin
                if (!synced) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == HOLD_LAST)) begin
                    state_d = BTN_REPEAT;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            BTN_REPEAT: begin
                if (!synced) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = BTN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ring_ctrl.sv
// Ring control: button events adjust a target ring state, which is committed
// to the renderer-facing outputs only on frame_begin.
module ring_ctrl
    import ring_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = BTN_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = BTN_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter int unsigned DIA_W         = 8,
    parameter int unsigned DIA_INIT      = 30,
    parameter int unsigned DIA_MIN       = 10,
    parameter int unsigned DIA_MAX       = 50,
    parameter int unsigned DIA_STEP      = 5,
    parameter int unsigned RING_WIDTH    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btnC,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             frame_begin,
    output logic             ring_active,
    output logic [DIA_W-1:0] outer_dia,
    output logic [DIA_W-1:0] inner_dia,
    output logic             update_pending
);

    localparam logic [DIA_W:0]   STEP_X  = (DIA_W+1)'(DIA_STEP);
    localparam logic [DIA_W:0]   MAX_X   = (DIA_W+1)'(DIA_MAX);
    localparam logic [DIA_W:0]   DNLIM_X = (DIA_W+1)'(DIA_MIN + DIA_STEP);
    localparam logic [DIA_W-1:0] INIT_V  = DIA_W'(DIA_INIT);
    localparam logic [DIA_W-1:0] STEP_V  = DIA_W'(DIA_STEP);

    logic             pulse_c, pulse_u, pulse_d;
    logic             tgt_active_q, tgt_active_d;
    logic [DIA_W-1:0] tgt_dia_q, tgt_dia_d;
    logic             ring_active_q, ring_active_d;
    logic [DIA_W-1:0] outer_dia_q, outer_dia_d;
    logic             pending_q, pending_d;
    logic [DIA_W:0]   dia_x;

    btn_event #(
        .DB_CYCLES    (DB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b0)
    ) u_btn_c (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btnC),
        .pulse_o(pulse_c)
    );

    btn_event #(
        .DB_CYCLES    (DB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_btn_u (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btnU),
        .pulse_o(pulse_u)
    );

    btn_event #(
        .DB_CYCLES    (DB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_btn_d (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btnD),
        .pulse_o(pulse_d)
    );

    // Target, committed and pending registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_active_q  <= 1'b0;
            tgt_dia_q     <= INIT_V;
            ring_active_q <= 1'b0;
            outer_dia_q   <= INIT_V;
            pending_q     <= 1'b0;
        end else begin
            tgt_active_q  <= tgt_active_d;
            tgt_dia_q     <= tgt_dia_d;
            ring_active_q <= ring_active_d;
            outer_dia_q   <= outer_dia_d;
            pending_q     <= pending_d;
        end
    end

    // Event handling on the targets; commit samples the pre-update targets.
    // Pending is computed from next-state values so it never lags a cycle.
    always_comb begin
        tgt_active_d  = tgt_active_q ^ pulse_c;
        tgt_dia_d     = tgt_dia_q;
        dia_x         = {1'b0, tgt_dia_q};
        if (tgt_active_q && !(pulse_u && pulse_d)) begin
            if (pulse_u && ((dia_x + STEP_X) <= MAX_X)) begin
                tgt_dia_d = tgt_dia_q + STEP_V;
            end else if (pulse_d && (dia_x >= DNLIM_X)) begin
                tgt_dia_d = tgt_dia_q - STEP_V;
            end
        end
        ring_active_d = frame_begin ? tgt_active_q : ring_active_q;
        outer_dia_d   = frame_begin ? tgt_dia_q : outer_dia_q;
        pending_d     = (tgt_active_d != ring_active_d) || (tgt_dia_d != outer_dia_d);
    end

    assign ring_active    = ring_active_q;
    assign outer_dia      = outer_dia_q;
    assign inner_dia      = outer_dia_q - DIA_W'(RING_WIDTH);
    assign update_pending = pending_q;

endmodule

// File: tb/tb_ring_ctrl.sv
// Self-checking bench for ring_ctrl with shortened button timing.
module tb_ring_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, frame_begin = 1'b0;
    logic       ring_active;
    logic [7:0] outer_dia, inner_dia;
    logic       update_pending;

    always #5 clk = ~clk;

    ring_ctrl #(
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btnC          (btnC),
        .btnU          (btnU),
        .btnD          (btnD),
        .frame_begin   (frame_begin),
        .ring_active   (ring_active),
        .outer_dia     (outer_dia),
        .inner_dia     (inner_dia),
        .update_pending(update_pending)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit fb_auto  = 1'b1;
    bit fb_force = 1'b0;

    // Reference model: targets, committed values, per-button synced history.
    int m_tact, m_tdia, m_ract, m_odia;
    bit m_hist[3][2];
    int m_run[3];
    bit m_pul[3];

    typedef struct {
        int btn;
        int hold;
        int exp_act;
        int exp_dia;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // A held button fires after DB+1 synced-high cycles, then (if repeating)
    // HOLD cycles later and every REP cycles after that.
    function automatic bit fire(input int s, input bit rep);
        if (s == DB + 1) return 1'b1;
        if (rep && s >= DB + 1 + HOLD && ((s - DB - 1 - HOLD) % REP) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_tact = 0; m_tdia = 30; m_ract = 0; m_odia = 30;
        for (int b = 0; b < 3; b++) begin
            m_hist[b][0] = 1'b0; m_hist[b][1] = 1'b0;
            m_run[b] = 0; m_pul[b] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit raw[3];
        int old_act, old_dia;
        raw[0] = btnC; raw[1] = btnU; raw[2] = btnD;
        old_act = m_tact;
        old_dia = m_tdia;
        if (frame_begin) begin
            m_ract = old_act;
            m_odia = old_dia;
        end
        if (m_pul[0]) m_tact = 1 - old_act;
        if (old_act == 1 && !(m_pul[1] && m_pul[2])) begin
            if (m_pul[1] && old_dia + 5 <= 50) m_tdia = old_dia + 5;
            else if (m_pul[2] && old_dia - 5 >= 10) m_tdia = old_dia - 5;
        end
        for (int b = 0; b < 3; b++) begin
            m_run[b] = m_hist[b][1] ? m_run[b] + 1 : 0;
            m_pul[b] = fire(m_run[b], b != 0);
            m_hist[b][1] = m_hist[b][0];
            m_hist[b][0] = raw[b];
        end
    endtask

    task automatic check_outputs();
        chk("ring_active", int'(ring_active), m_ract);
        chk("outer_dia", int'(outer_dia), m_odia);
        chk("inner_dia", int'(inner_dia), m_odia - 5);
        chk("update_pending", int'(update_pending),
            int'((m_tact != m_ract) || (m_tdia != m_odia)));
    endtask

    task automatic tick();
        frame_begin = fb_force || (fb_auto && ((cyc + 1) % 50 == 0));
        @(posedge clk);
        cyc++;
        if (reset) model_edge();
        else model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btnC = v;
            1: btnU = v;
            default: btnD = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        repeat (hold) tick();
        set_btn(b, 1'b0);
    endtask

    initial begin
        int rem[3];
        logic lvl[3];

        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Reset state, then idle cycles produce nothing.
        chk("rst_ring_active", int'(ring_active), 0);
        chk("rst_outer_dia", int'(outer_dia), 30);
        chk("rst_inner_dia", int'(inner_dia), 25);
        chk("rst_pending", int'(update_pending), 0);
        repeat (100) tick();
        chk("idle_outer_dia", int'(outer_dia), 30);
        chk("idle_pending", int'(update_pending), 0);

        // Press table: short C glitch, C toggle, U saturation, D saturation.
        tbl.push_back('{0, 3, 0, 30});
        tbl.push_back('{0, 10, 1, 30});
        tbl.push_back('{1, 6, 1, 35});
        tbl.push_back('{1, 6, 1, 40});
        tbl.push_back('{1, 6, 1, 45});
        tbl.push_back('{1, 6, 1, 50});
        tbl.push_back('{1, 6, 1, 50});
        for (int i = 0; i < 9; i++) begin
            int d;
            d = 45 - 5 * i;
            if (d < 10) d = 10;
            tbl.push_back('{2, 6, 1, d});
        end
        foreach (tbl[i]) begin
            press(tbl[i].btn, tbl[i].hold);
            repeat (60) tick();
            chk("vec_ring_active", int'(ring_active), tbl[i].exp_act);
            chk("vec_outer_dia", int'(outer_dia), tbl[i].exp_dia);
            chk("vec_pending", int'(update_pending), 0);
        end

        // Auto-repeat: 40-cycle hold gives press + 2 repeats, commit deferred.
        do_reset(2);
        press(0, 10);
        repeat (60) tick();
        fb_auto = 1'b0;
        press(1, 40);
        repeat (10) tick();
        chk("repeat_no_commit", int'(outer_dia), 30);
        chk("repeat_pending", int'(update_pending), 1);
        fb_force = 1'b1;
        tick();
        fb_force = 1'b0;
        tick();
        chk("repeat_commit_dia", int'(outer_dia), 45);
        chk("repeat_commit_pending", int'(update_pending), 0);
        fb_auto = 1'b1;

        // U and D pulses aligned: both discarded.
        btnU = 1'b1; btnD = 1'b1;
        repeat (6) tick();
        btnU = 1'b0; btnD = 1'b0;
        repeat (60) tick();
        chk("ud_same_dia", int'(outer_dia), 45);
        chk("ud_same_pending", int'(update_pending), 0);

        // Inactive: U discarded.
        press(0, 10);
        repeat (60) tick();
        chk("inactive_ring", int'(ring_active), 0);
        press(1, 6);
        repeat (60) tick();
        chk("inactive_u_dia", int'(outer_dia), 45);
        chk("inactive_u_ring", int'(ring_active), 0);
        chk("inactive_u_pending", int'(update_pending), 0);

        // Reset during U repeat with the button still held.
        press(0, 10);
        repeat (60) tick();
        btnU = 1'b1;
        repeat (35) tick();
        do_reset(3);
        chk("rst_repeat_dia", int'(outer_dia), 30);
        chk("rst_repeat_ring", int'(ring_active), 0);
        repeat (20) tick();
        btnU = 1'b0;
        repeat (5) tick();

        // Reset with C held: no toggle before a fresh qualification.
        btnC = 1'b1;
        repeat (10) tick();
        do_reset(2);
        for (int i = 0; i < 2 + DB; i++) begin
            tick();
            chk("no_early_pulse", int'(update_pending), 0);
        end
        repeat (10) tick();
        btnC = 1'b0;
        repeat (10) tick();

        // Randomised levels and frame timing against the model.
        fb_auto = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rem[b] = 0;
            lvl[b] = 1'b0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = logic'($urandom_range(0, 1));
                    rem[b] = int'($urandom_range(1, 40));
                end
                rem[b]--;
            end
            btnC = lvl[0]; btnU = lvl[1]; btnD = lvl[2];
            fb_force = ($urandom_range(0, 39) == 0);
            tick();
        end
        fb_force = 1'b0;
        btnC = 1'b0; btnU = 1'b0; btnD = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
